// File: rtl/upower_pkg.sv
// Shared decode constants, ALU codes and control-FSM types for the uPower
// R/I-format control block.
package upower_pkg;

  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_ORI  = 6'd24;
  localparam logic [5:0] OP_ANDI = 6'd28;
  localparam logic [5:0] OP_X31  = 6'd31;

  localparam logic [9:0] XO_ADD  = 10'd266;
  localparam logic [9:0] XO_SUBF = 10'd40;
  localparam logic [9:0] XO_AND  = 10'd28;
  localparam logic [9:0] XO_OR   = 10'd444;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    regdst;
    logic    alusrc;
    logic    xo;
    logic    legal;
  } ctrl_t;

endpackage

// File: rtl/upower_ri_control_if.sv
// Fetch-side handshake plus the registered control outputs of upower_ri_control.
interface upower_ri_control_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instruction;
  logic [3:0]       ALU_OP;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrc;
  logic             XO;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output instr_in, instr_valid,
    input  instr_ready, instruction, ALU_OP, RegWrite, RegDst, ALUSrc, XO,
           illegal, retired
  );

  modport slave (
    input  instr_in, instr_valid,
    output instr_ready, instruction, ALU_OP, RegWrite, RegDst, ALUSrc, XO,
           illegal, retired
  );

endinterface

// File: rtl/upower_ri_decode.sv
// Combinational decoder: instruction word -> ALU/operand-select controls and a
// legality flag. Unsupported encodings yield all-zero controls with legal=0.
module upower_ri_decode
  import upower_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] opcode;
  logic [9:0] xopcode;
  logic       unused_bits;

  assign opcode      = instr_i[31:26];
  assign xopcode     = instr_i[10:1];
  // Register fields and the Rc bit play no part in control selection.
  assign unused_bits = ^{instr_i[25:11], instr_i[0]};

  always_comb begin
    ctrl_o = '{alu_op: ALU_AND, regdst: 1'b0, alusrc: 1'b0, xo: 1'b0, legal: 1'b0};
    case (opcode)
      OP_ADDI: ctrl_o = '{alu_op: ALU_ADD, regdst: 1'b0, alusrc: 1'b1, xo: 1'b1, legal: 1'b1};
      OP_ANDI: ctrl_o = '{alu_op: ALU_AND, regdst: 1'b0, alusrc: 1'b1, xo: 1'b0, legal: 1'b1};
      OP_ORI:  ctrl_o = '{alu_op: ALU_OR,  regdst: 1'b0, alusrc: 1'b1, xo: 1'b0, legal: 1'b1};
      OP_X31: begin
        case (xopcode)
          XO_ADD:  ctrl_o = '{alu_op: ALU_ADD, regdst: 1'b1, alusrc: 1'b0, xo: 1'b1, legal: 1'b1};
          XO_SUBF: ctrl_o = '{alu_op: ALU_SUB, regdst: 1'b1, alusrc: 1'b0, xo: 1'b1, legal: 1'b1};
          XO_AND:  ctrl_o = '{alu_op: ALU_AND, regdst: 1'b1, alusrc: 1'b0, xo: 1'b0, legal: 1'b1};
          XO_OR:   ctrl_o = '{alu_op: ALU_OR,  regdst: 1'b1, alusrc: 1'b0, xo: 1'b0, legal: 1'b1};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/upower_ri_control.sv
// Four-state control sequencer for the uPower R/I datapath: accept, decode,
// execute, write back; one instruction every four cycles.
module upower_ri_control
  import upower_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  upower_ri_control_if.slave   bus
);

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  alu_op_t          alu_op_q, alu_op_d;
  logic             regdst_q, regdst_d;
  logic             alusrc_q, alusrc_d;
  logic             xo_q, xo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ready, regwrite, illegal;
  ctrl_t            dec;

  upower_ri_decode u_decode (
    .instr_i (instr_q),
    .ctrl_o  (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      alu_op_q  <= ALU_AND;
      regdst_q  <= 1'b0;
      alusrc_q  <= 1'b0;
      xo_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_op_q  <= alu_op_d;
      regdst_q  <= regdst_d;
      alusrc_q  <= alusrc_d;
      xo_q      <= xo_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_op_d  = alu_op_q;
    regdst_d  = regdst_q;
    alusrc_d  = alusrc_q;
    xo_d      = xo_q;
    retired_d = retired_q;
    ready     = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instr_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_op_d = dec.alu_op;
        regdst_d = dec.regdst;
        alusrc_d = dec.alusrc;
        xo_d     = dec.xo;
        if (dec.legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end
      end
      // Count on entry to WB so retired already includes the instruction
      // whose RegWrite pulse is visible; a reset before WB drops both.
      ST_EXEC: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_WB;
      end
      ST_WB: begin
        regwrite = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.instr_ready = ready;
  assign bus.instruction = instr_q;
  assign bus.ALU_OP      = alu_op_q;
  assign bus.RegDst      = regdst_q;
  assign bus.ALUSrc      = alusrc_q;
  assign bus.XO          = xo_q;
  assign bus.RegWrite    = regwrite;
  assign bus.illegal     = illegal;
  assign bus.retired     = retired_q;

endmodule

// File: doc/upower_ri_control.md
UPOWER_RI_CONTROL -- requirements
Module: upower_ri_control

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_in  input  32  uPower instruction word offered by the fetch side.
REQ-005 instr_valid  input  1  instr_in holds a valid instruction.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 instruction  output  32  registered instruction word driven to the R/I datapath.
REQ-008 ALU_OP  output  4  ALU control code: 0000 and, 0001 or, 0010 add, 0110 sub.
REQ-009 RegWrite  output  1  register-file write enable.
REQ-010 RegDst  output  1  1 = X/XO-form (register operand), 0 = D-form.
REQ-011 ALUSrc  output  1  1 = sign-extended immediate, 0 = register rb.
REQ-012 XO  output  1  1 = dest in bits[25:21], source in bits[20:16]; 0 = swapped.
REQ-013 illegal  output  1  one-cycle pulse: decoded instruction unsupported.
REQ-014 retired  output  CNT_W  count of instructions that completed write-back.

Function
REQ-015 Decode uses primary opcode bits[31:26]; for opcode 31, extended opcode bits[10:1]; bit 0 (Rc) ignored.
REQ-016 Supported: addi (14): ALU_OP 0010, ALUSrc 1, RegDst 0, XO 1.
REQ-017 andi. (28): ALU_OP 0000, ALUSrc 1, RegDst 0, XO 0.
REQ-018 ori (24): ALU_OP 0001, ALUSrc 1, RegDst 0, XO 0.
REQ-019 Opcode 31: add (XO 266) → ALU_OP 0010, XO 1; subf (XO 40) → ALU_OP 0110, XO 1; and (XO 28) → ALU_OP 0000, XO 0; or (XO 444) → ALU_OP 0001, XO 0. All have ALUSrc 0, RegDst 1.
REQ-020 Any other encoding is illegal.
REQ-021 FSM states IDLE, DECODE, EXEC, WB.
REQ-022 IDLE: instr_ready=1; when instr_valid=1, latch instr_in into instruction, go to DECODE; otherwise stay in IDLE.
REQ-023 DECODE: instr_ready=0; register the decoded controls. If legal, go to EXEC. If illegal, pulse illegal for this one cycle, keep RegWrite=0, and return to IDLE.
REQ-024 EXEC: hold instruction and controls stable, RegWrite=0; go to WB.
REQ-025 WB: RegWrite=1 for exactly this cycle; increment retired; go to IDLE.
REQ-026 Latency: instruction accepted at edge N → RegWrite high during cycle N+3 → instr_ready high again in cycle N+4; throughput one instruction per 4 cycles.
REQ-027 instruction, ALU_OP, RegDst, ALUSrc and XO hold their last values through IDLE until the next acceptance.
REQ-028 RegWrite is never asserted outside WB.
REQ-029 retired wraps from 2^CNT_W-1 to 0 without a flag.
REQ-030 instr_valid is ignored when instr_ready=0; no buffering and no back-pressure on the producer beyond instr_ready.

Reset
REQ-031 While rst=1 at a rising edge:
- FSM goes to IDLE.
- instruction, ALU_OP, RegDst, ALUSrc, XO, RegWrite, illegal and retired become 0.
REQ-032 Reset in any state aborts the in-flight instruction: no RegWrite pulse, no retired increment.
REQ-033 instr_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 Shared package upower_pkg holds:
- primary opcode constants (14, 24, 28, 31);
- extended opcode constants (266, 40, 28, 444);
- ALU_OP codes;
- the FSM state enum.
REQ-035 One combinational sub-module upower_ri_decode maps a 32-bit word to {ALU_OP, RegDst, ALUSrc, XO, legal}; the FSM and registers live in upower_ri_control.

Verification
REQ-036 Reset, then offer 0x7E000A14 (add R16,R0,R1) → in cycle N+3: ALU_OP=0010, RegDst=1, ALUSrc=0, XO=1, RegWrite=1; retired=1.
REQ-037 Offer 0x3A200014 (addi), 0x70D60000 (andi.), 0x61170000 (ori) back-to-back with instr_valid held high → each accepted 4 cycles apart; XO=1, 0, 0; ALUSrc=1; retired=3.
REQ-038 Offer 0x7CD83839 (and R24,R6,R7) → ALU_OP=0000, XO=0, RegDst=1; Rc bit ignored.
REQ-039 Offer 0x04000000 (opcode 1) → illegal pulses in cycle N+1, RegWrite stays 0, retired unchanged, instr_ready=1 in cycle N+2.
REQ-040 Assert rst during EXEC → no RegWrite pulse, all outputs 0 next cycle, instr_ready=1.
REQ-041 With CNT_W=4, retire 16 addi instructions → retired returns to 0.
